// File: rtl/cordic_unit_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : cordic_unit_scheduler
// Purpose  : Round-robin scheduler that shares one iterative CORDIC
//            MAC/activation unit among NUM_REQ neuron-lane requesters.
//            It grants one request, issues it to the unit, waits for
//            cu_done or a watchdog timeout, then returns the result.
// Options  : AF_PRIORITY_EN - when defined, activation requests (req_op=1)
//            pre-empt MAC requests in arbitration. The round-robin pointer
//            is shared by both classes.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_unit_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_x,
  input  logic [NUM_REQ*DATA_W-1:0] req_y,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      cu_start,
  output logic                      cu_op,
  output logic [DATA_W-1:0]         cu_x,
  output logic [DATA_W-1:0]         cu_y,
  input  logic                      cu_done,
  input  logic [DATA_W-1:0]         cu_result,
  output logic                      resp_valid,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      busy,
  output logic                      timeout_err,
  input  logic                      clr_err
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [ID_W-1:0]     ptr;       // last granted lane; also the lane in service
  logic [ID_W-1:0]     win;
  logic [ID_W-1:0]     cand;
  logic                found;
  logic [NUM_REQ-1:0]  elig;
  logic [WD_W-1:0]     wdog;
  logic                issue;
  logic                finish;
  logic                expire;

`ifdef AF_PRIORITY_EN
  // Activation requesters form the arbitration set whenever any is present.
  logic [NUM_REQ-1:0] act_req;
  assign act_req = req & req_op;
  assign elig    = (|act_req) ? act_req : (req & ~req_op);
`else
  // Pure round-robin over every requester; the op only travels to the unit.
  assign elig = req;
`endif

  // Round-robin search upward from the lane after the last grant, with wrap.
  always_comb begin
    win   = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && elig[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and event decode; a done on the watchdog edge wins over expiry.
  always_comb begin
    state_n = state;
    issue   = 1'b0;
    finish  = 1'b0;
    expire  = 1'b0;
    case (state)
      S_IDLE: begin
        if (found) begin
          issue   = 1'b1;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cu_done) begin
          finish  = 1'b1;
          state_n = S_IDLE;
        end else if (wdog == WD_LAST) begin
          finish  = 1'b1;
          expire  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Registered outputs, pointer and watchdog; operands stay held through WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= ID_W'(NUM_REQ - 1);
      wdog        <= '0;
      gnt         <= '0;
      cu_start    <= 1'b0;
      cu_op       <= 1'b0;
      cu_x        <= '0;
      cu_y        <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_data   <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      gnt        <= '0;
      cu_start   <= 1'b0;
      resp_valid <= 1'b0;

      if (issue) begin
        gnt      <= NUM_REQ'(1) << win;
        cu_start <= 1'b1;
        cu_op    <= req_op[win];
        cu_x     <= req_x[win*DATA_W +: DATA_W];
        cu_y     <= req_y[win*DATA_W +: DATA_W];
        busy     <= 1'b1;
        ptr      <= win;
        wdog     <= '0;
      end else if (state == S_WAIT && !finish) begin
        wdog <= wdog + WD_W'(1);
      end

      if (finish) begin
        resp_valid <= 1'b1;
        resp_id    <= ptr;
        resp_data  <= expire ? '0 : cu_result;
        busy       <= 1'b0;
      end

      if (expire) begin
        timeout_err <= 1'b1;
      end else if (clr_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cordic_unit_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_unit_scheduler
// Purpose  : Self-checking bench for cordic_unit_scheduler with a behavioural
//            CORDIC unit model and a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_unit_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 64;
  localparam int ID_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_op;
  logic [NUM_REQ*DATA_W-1:0] req_x;
  logic [NUM_REQ*DATA_W-1:0] req_y;
  logic [NUM_REQ-1:0]        gnt;
  logic                      cu_start;
  logic                      cu_op;
  logic [DATA_W-1:0]         cu_x;
  logic [DATA_W-1:0]         cu_y;
  logic                      cu_done;
  logic [DATA_W-1:0]         cu_result;
  logic                      resp_valid;
  logic [ID_W-1:0]           resp_id;
  logic [DATA_W-1:0]         resp_data;
  logic                      busy;
  logic                      timeout_err;
  logic                      clr_err;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } resp_t;

  resp_t sb[$];
  int    checks = 0;
  int    passed = 0;
  int    model_lat = 10;   // cycles from cu_start to cu_done; -1 = never

  cordic_unit_scheduler #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_x(req_x),
    .req_y(req_y), .gnt(gnt), .cu_start(cu_start), .cu_op(cu_op),
    .cu_x(cu_x), .cu_y(cu_y), .cu_done(cu_done), .cu_result(cu_result),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .busy(busy), .timeout_err(timeout_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // CORDIC unit model: MAC returns x+y, activation returns x^y.
  initial begin : unit_model
    int cnt;
    logic pend;
    logic [DATA_W-1:0] res;
    cu_done = 1'b0; cu_result = '0; pend = 1'b0; cnt = 0; res = '0;
    forever begin
      @(negedge clk);
      cu_done = 1'b0;
      if (cu_start) begin
        pend = 1'b1; cnt = 0;
        res = cu_op ? (cu_x ^ cu_y) : (cu_x + cu_y);
      end else if (pend) begin
        cnt++;
      end
      if (pend && model_lat >= 0 && cnt == model_lat) begin
        cu_done = 1'b1; cu_result = res; pend = 1'b0;
      end
    end
  end

  // Response scoreboard.
  always @(negedge clk) begin : resp_monitor
    resp_t e;
    if (!rst && resp_valid) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL resp_unexpected: got id=%0d data=%h, none expected", resp_id, resp_data);
      end else begin
        e = sb.pop_front();
        if ({resp_id, resp_data} !== e)
          $display("FAIL resp_match: got id=%0d data=%h, want id=%0d data=%h",
                   resp_id, resp_data, e.id, e.data);
        else
          passed++;
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b1; req = '0; req_op = '0; req_x = '0; req_y = '0; clr_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_op = '0; req_x = '0; req_y = '0; clr_err = 1'b0;
    #1;
    checks++;
    if ({gnt, cu_start, cu_op, cu_x, cu_y, resp_valid, resp_id, resp_data, busy, timeout_err} !== '0)
      $display("FAIL reset_outputs: outputs not all zero (gnt=%b busy=%b)", gnt, busy);
    else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt, cu_start, busy, resp_valid} !== '0)
      $display("FAIL reset_idle: gnt=%b start=%b busy=%b, want all 0", gnt, cu_start, busy);
    else passed++;
  endtask

  task automatic test_single();
    int lat;
    apply_reset();
    model_lat = 10;
    req[2] = 1'b1; req_op[2] = 1'b0;
    req_x[2*DATA_W +: DATA_W] = 16'h0100;
    req_y[2*DATA_W +: DATA_W] = 16'h0200;
    sb.push_back('{id: 2'd2, data: 16'h0300});
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100 || cu_start !== 1'b1 || busy !== 1'b1)
      $display("FAIL single_grant: gnt=%b start=%b busy=%b, want 0100 1 1", gnt, cu_start, busy);
    else passed++;
    checks++;
    if (cu_op !== 1'b0 || cu_x !== 16'h0100 || cu_y !== 16'h0200)
      $display("FAIL single_operands: op=%b x=%h y=%h, want 0 0100 0200", cu_op, cu_x, cu_y);
    else passed++;
    req = '0;
    @(negedge clk);
    lat = 1;
    checks++;
    if (gnt !== '0 || cu_start !== 1'b0 || cu_x !== 16'h0100)
      $display("FAIL single_pulse: gnt=%b start=%b x=%h, want 0000 0 0100", gnt, cu_start, cu_x);
    else passed++;
    while (!resp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 11 || busy !== 1'b0)
      $display("FAIL single_latency: resp at cycle %0d busy=%b, want cycle 11 busy 0", lat, busy);
    else passed++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_round_robin();
    int ng;
    int got;
    int cyc;
    apply_reset();
    model_lat = 3;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_x[k*DATA_W +: DATA_W] = DATA_W'(16'h0010 * (k + 1));
      req_y[k*DATA_W +: DATA_W] = DATA_W'(k);
    end
    req = 4'b1111;
    ng = 0; cyc = 0;
    while (ng < 5 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (resp_valid && ng < 5) req[resp_id] = 1'b1;
      if (gnt !== '0) begin
        got = -1;
        for (int k = 0; k < NUM_REQ; k++) if (gnt[k]) begin got = k; req[k] = 1'b0; end
        checks++;
        if (!$onehot(gnt) || got != (ng % NUM_REQ))
          $display("FAIL rr_order: grant %0d gnt=%b, want lane %0d", ng, gnt, ng % NUM_REQ);
        else passed++;
        sb.push_back('{id: ID_W'(ng % NUM_REQ),
                       data: DATA_W'(16'h0010 * ((ng % NUM_REQ) + 1) + (ng % NUM_REQ))});
        ng++;
      end
    end
    req = '0;
    checks++;
    if (ng != 5) $display("FAIL rr_count: saw %0d grants, want 5", ng);
    else passed++;
    cyc = 0;
    while (sb.size() != 0 && cyc < 50) begin @(negedge clk); cyc++; end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int lat;
    apply_reset();
    model_lat = -1;
    req[1] = 1'b1;
    req_x[1*DATA_W +: DATA_W] = 16'h0005;
    req_y[1*DATA_W +: DATA_W] = 16'h0006;
    sb.push_back('{id: 2'd1, data: 16'h0000});
    @(negedge clk);
    req = '0;
    lat = 0;
    while (!resp_valid && lat < 200) begin @(negedge clk); lat++; end
    checks++;
    if (lat !== 64 || timeout_err !== 1'b1 || busy !== 1'b0)
      $display("FAIL timeout_resp: cycle %0d err=%b busy=%b, want 64 1 0", lat, timeout_err, busy);
    else passed++;
    repeat (3) @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1) $display("FAIL timeout_sticky: err=%b, want 1", timeout_err);
    else passed++;
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) $display("FAIL timeout_clear: err=%b, want 0", timeout_err);
    else passed++;
    // clr_err held across a second expiry: the set must win on that edge.
    req[1] = 1'b1;
    clr_err = 1'b1;
    sb.push_back('{id: 2'd1, data: 16'h0000});
    @(negedge clk);
    req = '0;
    lat = 0;
    while (!resp_valid && lat < 200) begin @(negedge clk); lat++; end
    checks++;
    if (timeout_err !== 1'b1) $display("FAIL timeout_set_wins: err=%b, want 1", timeout_err);
    else passed++;
    @(negedge clk);
    clr_err = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) $display("FAIL timeout_clear2: err=%b, want 0", timeout_err);
    else passed++;
    model_lat = 10;
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    apply_reset();
    model_lat = 10;
    req[0] = 1'b1;
    req_x[0 +: DATA_W] = 16'h0042;
    @(negedge clk);
    req = '0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt, cu_start, cu_op, cu_x, cu_y, resp_valid, resp_id, resp_data, busy, timeout_err} !== '0)
      $display("FAIL midwait_reset: busy=%b x=%h, want all outputs 0", busy, cu_x);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (resp_valid || busy || gnt !== '0) seen++;
    end
    checks++;
    if (seen != 0) $display("FAIL midwait_noresp: %0d active cycles after reset, want 0", seen);
    else passed++;
  endtask

  task automatic test_priority();
    logic [NUM_REQ-1:0] first;
    logic [NUM_REQ-1:0] second;
    int cyc;
`ifdef AF_PRIORITY_EN
    first = 4'b1000; second = 4'b0001;
`else
    first = 4'b0001; second = 4'b1000;
`endif
    apply_reset();
    model_lat = 3;
    req_x[0 +: DATA_W] = 16'h0011;        req_y[0 +: DATA_W] = 16'h0022;
    req_x[3*DATA_W +: DATA_W] = 16'h0300; req_y[3*DATA_W +: DATA_W] = 16'h0044;
    req_op = 4'b1000;
    req = 4'b1001;
    @(negedge clk);
    checks++;
    if (gnt !== first) $display("FAIL prio_first: gnt=%b, want %b", gnt, first);
    else passed++;
    sb.push_back(first[3] ? '{id: 2'd3, data: 16'h0344} : '{id: 2'd0, data: 16'h0033});
    req = req & ~first;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (gnt === '0 && cyc < 100);
    checks++;
    if (gnt !== second) $display("FAIL prio_second: gnt=%b, want %b", gnt, second);
    else passed++;
    sb.push_back(second[3] ? '{id: 2'd3, data: 16'h0344} : '{id: 2'd0, data: 16'h0033});
    req = '0;
    cyc = 0;
    while (sb.size() != 0 && cyc < 50) begin @(negedge clk); cyc++; end
    @(negedge clk);
  endtask

  task automatic test_done_at_timeout();
    int lat;
    int seen;
    apply_reset();
    model_lat = 63;   // done sampled on the edge where wdog==TIMEOUT-1
    req[2] = 1'b1;
    req_x[2*DATA_W +: DATA_W] = 16'h1000;
    req_y[2*DATA_W +: DATA_W] = 16'h0234;
    sb.push_back('{id: 2'd2, data: 16'h1234});
    @(negedge clk);
    req = '0;
    lat = 0;
    while (!resp_valid && lat < 200) begin @(negedge clk); lat++; end
    checks++;
    if (lat !== 64 || timeout_err !== 1'b0)
      $display("FAIL done_wins: cycle %0d err=%b, want 64 0", lat, timeout_err);
    else passed++;
    // Done one cycle too late: expiry response, then the stray done is ignored.
    repeat (2) @(negedge clk);
    model_lat = 64;
    req[2] = 1'b1;
    sb.push_back('{id: 2'd2, data: 16'h0000});
    @(negedge clk);
    req = '0;
    lat = 0;
    while (!resp_valid && lat < 200) begin @(negedge clk); lat++; end
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid || busy) seen++;
    end
    checks++;
    if (lat !== 64 || seen != 0 || timeout_err !== 1'b1)
      $display("FAIL late_done: cycle %0d extra=%0d err=%b, want 64 0 1", lat, seen, timeout_err);
    else passed++;
    model_lat = 10;
  endtask

  initial begin
    rst = 1'b1; req = '0; req_op = '0; req_x = '0; req_y = '0; clr_err = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_reset_mid_wait();
    test_priority();
    test_done_at_timeout();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) $display("FAIL sb_drain: %0d responses outstanding, want 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
